// File: rtl/control_unit_pkg.sv
// control_unit_pkg: opcodes, state/FunSel/mux/ALU codes and idle pattern; CTRL_STACK_EN enables PUSH/POP
package control_unit_pkg;
  typedef enum logic [2:0] {S_RESET, S_T0, S_T1, S_T2, S_T3, S_HALT} state_t;
  localparam logic [3:0] OP_LD = 4'h0, OP_ST = 4'h1, OP_LDI = 4'h2, OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4, OP_AND = 4'h5, OP_INC = 4'h6, OP_DEC = 4'h7;
  localparam logic [3:0] OP_BRA = 4'h8, OP_BEQ = 4'h9, OP_PUSH = 4'hA, OP_POP = 4'hB, OP_HLT = 4'hF;
  localparam logic [1:0] FS_DEC = 2'b00, FS_INC = 2'b01, FS_LOAD = 2'b10, FS_CLR = 2'b11;
  localparam logic [1:0] MUXA_IMM = 2'b00, MUXA_MEM = 2'b01, MUXA_ALU = 2'b11, MUXB_IMM = 2'b01;
  localparam logic [1:0] DSEL_PC = 2'b00, DSEL_AR = 2'b10, DSEL_SP = 2'b11;
  localparam logic [3:0] ALU_PASSA = 4'b0000, ALU_ADD = 4'b0100, ALU_SUB = 4'b0110, ALU_AND = 4'b0111;
  localparam logic [3:0] RF_NONE = 4'b1111;
  localparam logic [2:0] ARF_NONE = 3'b111, ARF_PC = 3'b110, ARF_AR = 3'b101, ARF_SP = 3'b011;
  // Active-low one-hot register enable for Rn.
  function automatic logic [3:0] rf_sel(input logic [1:0] rn);
    return ~(4'b0001 << rn);
  endfunction
  function automatic logic [3:0] alu_code(input logic [3:0] op);
    return op == OP_ADD ? ALU_ADD : op == OP_SUB ? ALU_SUB : ALU_AND;
  endfunction
  // Opcodes that need T3 before returning to fetch.
  function automatic logic is_long(input logic [3:0] op);
    logic l;
    l = op inside {OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND};
`ifdef CTRL_STACK_EN
    l = l || op inside {OP_PUSH, OP_POP};
`endif
    return l;
  endfunction
endpackage

// File: rtl/control_unit_seq.sv
// ctrl_seq: T-state register with sync reset, HALT latch and next-state logic; CTRL_STACK_EN lengthens PUSH/POP
module ctrl_seq
  import control_unit_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_opcode,
  output state_t     o_state
);
  state_t r_state, w_next;
  // State register; reset wins over everything, HALT only exits through it.
  always_ff @(posedge i_clk)
    r_state <= i_rst ? S_RESET : w_next;
  // Fetch twice, execute one or two T-states, then back to T0 without a gap.
  always_comb
    w_next = r_state == S_RESET ? S_T0 :
             r_state == S_T0    ? S_T1 :
             r_state == S_T1    ? S_T2 :
             r_state == S_T2    ? (i_opcode == OP_HLT ? S_HALT : is_long(i_opcode) ? S_T3 : S_T0) :
             r_state == S_T3    ? S_T0 : S_HALT;
  assign o_state = r_state;
endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired fetch/decode/execute controller for ALUSystem; CTRL_STACK_EN enables PUSH/POP
module control_unit
  import control_unit_pkg::*;
#(
  parameter logic [7:0] MEM_INIT_PC = 8'h00
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic [3:0]  ALU_Flag,
  output logic [1:0]  RF_OutASel,
  output logic [1:0]  RF_OutBSel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Enable,
  output logic [1:0]  IR_Funsel,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic        Halt
);
  state_t w_state;
  logic [3:0] w_op;
  logic [1:0] w_rn, w_rs;
  logic w_unused;
  assign w_op = IROut[15:12];
  assign w_rn = IROut[11:10];
  assign w_rs = IROut[1:0];
  assign w_unused = &{1'b0, IROut[9:2], ALU_Flag[3:1]};
  ctrl_seq u_seq (.i_clk(CLK), .i_rst(Reset), .i_opcode(w_op), .o_state(w_state));
  // Output decode: idle pattern first, then per-state/opcode overrides.
  always_comb begin
    RF_OutASel = 2'b00;
    RF_OutBSel = 2'b00;
    RF_FunSel = FS_LOAD;
    RF_RegSel = RF_NONE;
    ALU_FunSel = ALU_PASSA;
    ARF_OutCSel = 2'b00;
    ARF_OutDSel = DSEL_PC;
    ARF_FunSel = FS_LOAD;
    ARF_RegSel = ARF_NONE;
    IR_LH = 1'b0;
    IR_Enable = 1'b0;
    IR_Funsel = FS_LOAD;
    Mem_WR = 1'b0;
    Mem_CS = 1'b1;
    MuxASel = 2'b00;
    MuxBSel = 2'b00;
    MuxCSel = 1'b0;
    Halt = 1'b0;
    case (w_state)
      S_RESET: begin
        RF_RegSel = 4'b0000;
        RF_FunSel = FS_CLR;
        ARF_RegSel = 3'b000;
        ARF_FunSel = MEM_INIT_PC == 8'h00 ? FS_CLR : FS_LOAD;
        MuxBSel = MEM_INIT_PC == 8'h00 ? 2'b00 : MUXB_IMM;
      end
      S_T0, S_T1: begin
        Mem_CS = 1'b0;
        IR_Enable = 1'b1;
        IR_LH = w_state == S_T1;
        ARF_RegSel = ARF_PC;
        ARF_FunSel = FS_INC;
      end
      S_T2:
        case (w_op)
          OP_LD, OP_ST: begin
            MuxBSel = MUXB_IMM;
            ARF_RegSel = ARF_AR;
          end
          OP_LDI: RF_RegSel = rf_sel(w_rn);
          OP_ADD, OP_SUB, OP_AND: begin
            RF_OutASel = w_rn;
            RF_OutBSel = w_rs;
            MuxCSel = 1'b1;
            ALU_FunSel = alu_code(w_op);
          end
          OP_INC, OP_DEC: begin
            RF_RegSel = rf_sel(w_rn);
            RF_FunSel = w_op == OP_INC ? FS_INC : FS_DEC;
          end
          OP_BRA, OP_BEQ:
            if (w_op == OP_BRA || ALU_Flag[0]) begin
              MuxBSel = MUXB_IMM;
              ARF_RegSel = ARF_PC;
            end
`ifdef CTRL_STACK_EN
          OP_PUSH: begin
            RF_OutASel = w_rn;
            MuxCSel = 1'b1;
            ARF_OutDSel = DSEL_SP;
            Mem_CS = 1'b0;
            Mem_WR = 1'b1;
          end
          OP_POP: begin
            ARF_RegSel = ARF_SP;
            ARF_FunSel = FS_INC;
          end
`endif
          default: ;
        endcase
      S_T3:
        case (w_op)
          OP_LD: begin
            ARF_OutDSel = DSEL_AR;
            Mem_CS = 1'b0;
            MuxASel = MUXA_MEM;
            RF_RegSel = rf_sel(w_rn);
          end
          OP_ST: begin
            RF_OutASel = w_rn;
            MuxCSel = 1'b1;
            ARF_OutDSel = DSEL_AR;
            Mem_CS = 1'b0;
            Mem_WR = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            RF_OutASel = w_rn;
            RF_OutBSel = w_rs;
            MuxCSel = 1'b1;
            ALU_FunSel = alu_code(w_op);
            MuxASel = MUXA_ALU;
            RF_RegSel = rf_sel(w_rn);
          end
`ifdef CTRL_STACK_EN
          OP_PUSH: begin
            ARF_RegSel = ARF_SP;
            ARF_FunSel = FS_DEC;
          end
          OP_POP: begin
            ARF_OutDSel = DSEL_SP;
            Mem_CS = 1'b0;
            MuxASel = MUXA_MEM;
            RF_RegSel = rf_sel(w_rn);
          end
`endif
          default: ;
        endcase
      S_HALT: Halt = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed-vector check of control_unit state sequencing and output decode
module tb_control_unit;
  logic CLK = 1'b0;
  logic Reset = 1'b1;
  logic [15:0] IROut = 16'h0000;
  logic [3:0] ALU_Flag = 4'h0;
  logic [1:0] RF_OutASel, RF_OutBSel, RF_FunSel, ALU_unused, ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
  logic [3:0] RF_RegSel, ALU_FunSel;
  logic [2:0] ARF_RegSel;
  logic IR_LH, IR_Enable, Mem_WR, Mem_CS, MuxCSel, Halt;
  logic [1:0] IR_Funsel, MuxASel, MuxBSel;
  int n_chk = 0;
  int n_fail = 0;
  always #5 CLK = ~CLK;
  control_unit dut (
    .CLK(CLK), .Reset(Reset), .IROut(IROut), .ALU_Flag(ALU_Flag),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel), .RF_RegSel(RF_RegSel),
    .ALU_FunSel(ALU_FunSel), .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
    .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH), .IR_Enable(IR_Enable),
    .IR_Funsel(IR_Funsel), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel),
    .MuxBSel(MuxBSel), .MuxCSel(MuxCSel), .Halt(Halt)
  );
  assign ALU_unused = 2'b00;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge CLK);
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, "_rf"}, RF_RegSel, 8'h0F);
    chk({tag, "_arf"}, ARF_RegSel, 8'h07);
    chk({tag, "_cs"}, Mem_CS, 8'h01);
    chk({tag, "_wr"}, Mem_WR, 8'h00);
    chk({tag, "_ir"}, IR_Enable, 8'h00);
    chk({tag, "_rffs"}, RF_FunSel, 8'h02);
  endtask
  // Starts at a T0 negedge, ends at the T2 negedge.
  task automatic fetch(input logic [15:0] ir);
    IROut = ir;
    chk("t0_cs", Mem_CS, 8'h00);
    chk("t0_en", IR_Enable, 8'h01);
    chk("t0_lh", IR_LH, 8'h00);
    chk("t0_pc", ARF_RegSel, 8'h06);
    chk("t0_pcfs", ARF_FunSel, 8'h01);
    chk("t0_dsel", ARF_OutDSel, 8'h00);
    tick;
    chk("t1_lh", IR_LH, 8'h01);
    chk("t1_en", IR_Enable, 8'h01);
    chk("t1_pc", ARF_RegSel, 8'h06);
    tick;
  endtask
  initial begin
    tick;
    tick;
    chk("rst_rffs", RF_FunSel, 8'h03);
    chk("rst_arffs", ARF_FunSel, 8'h03);
    chk("rst_rf", RF_RegSel, 8'h00);
    chk("rst_arf", ARF_RegSel, 8'h00);
    chk("rst_halt", Halt, 8'h00);
    Reset = 1'b0;
    tick;
    fetch(16'h205A);
    chk("ldi_rf", RF_RegSel, 8'h0E);
    chk("ldi_fs", RF_FunSel, 8'h02);
    chk("ldi_mxa", MuxASel, 8'h00);
    chk("ldi_cs", Mem_CS, 8'h01);
    tick;
    fetch(16'h2403);
    chk("ldi2_rf", RF_RegSel, 8'h0D);
    tick;
    fetch(16'h4001);
    chk("sub2_oa", RF_OutASel, 8'h00);
    chk("sub2_ob", RF_OutBSel, 8'h01);
    chk("sub2_alu", ALU_FunSel, 8'h06);
    chk("sub2_mxc", MuxCSel, 8'h01);
    chk("sub2_rf", RF_RegSel, 8'h0F);
    tick;
    chk("sub3_alu", ALU_FunSel, 8'h06);
    chk("sub3_mxa", MuxASel, 8'h03);
    chk("sub3_rf", RF_RegSel, 8'h0E);
    chk("sub3_ob", RF_OutBSel, 8'h01);
    tick;
    ALU_Flag = 4'b0001;
    fetch(16'h9040);
    chk("beq1_arf", ARF_RegSel, 8'h06);
    chk("beq1_fs", ARF_FunSel, 8'h02);
    chk("beq1_mxb", MuxBSel, 8'h01);
    tick;
    ALU_Flag = 4'b1110;
    fetch(16'h9040);
    chk("beq0_arf", ARF_RegSel, 8'h07);
    chk("beq0_mxb", MuxBSel, 8'h00);
    tick;
    fetch(16'h1080);
    chk("st2_arf", ARF_RegSel, 8'h05);
    chk("st2_mxb", MuxBSel, 8'h01);
    chk("st2_fs", ARF_FunSel, 8'h02);
    tick;
    chk("st3_wr", Mem_WR, 8'h01);
    chk("st3_cs", Mem_CS, 8'h00);
    chk("st3_dsel", ARF_OutDSel, 8'h02);
    chk("st3_mxc", MuxCSel, 8'h01);
    chk("st3_alu", ALU_FunSel, 8'h00);
    chk("st3_oa", RF_OutASel, 8'h00);
    tick;
    fetch(16'h0880);
    chk("ld2_arf", ARF_RegSel, 8'h05);
    tick;
    chk("ld3_dsel", ARF_OutDSel, 8'h02);
    chk("ld3_cs", Mem_CS, 8'h00);
    chk("ld3_wr", Mem_WR, 8'h00);
    chk("ld3_mxa", MuxASel, 8'h01);
    chk("ld3_rf", RF_RegSel, 8'h0B);
    tick;
    fetch(16'h6C00);
    chk("inc_rf", RF_RegSel, 8'h07);
    chk("inc_fs", RF_FunSel, 8'h01);
    tick;
    fetch(16'h7C00);
    chk("dec_fs", RF_FunSel, 8'h00);
    tick;
    fetch(16'h3400);
    chk("add2_alu", ALU_FunSel, 8'h04);
    chk("add2_oa", RF_OutASel, 8'h01);
    tick;
    chk("add3_rf", RF_RegSel, 8'h0D);
    tick;
    fetch(16'h5000);
    tick;
    chk("and3_alu", ALU_FunSel, 8'h07);
    chk("and3_mxa", MuxASel, 8'h03);
    tick;
    fetch(16'h8010);
    chk("bra_arf", ARF_RegSel, 8'h06);
    chk("bra_mxb", MuxBSel, 8'h01);
    tick;
    fetch(16'hC000);
    idle_chk("nop");
    tick;
    fetch(16'hA000);
`ifdef CTRL_STACK_EN
    chk("push2_wr", Mem_WR, 8'h01);
    chk("push2_cs", Mem_CS, 8'h00);
    chk("push2_dsel", ARF_OutDSel, 8'h03);
    chk("push2_mxc", MuxCSel, 8'h01);
    tick;
    chk("push3_arf", ARF_RegSel, 8'h03);
    chk("push3_fs", ARF_FunSel, 8'h00);
`else
    idle_chk("push");
`endif
    tick;
    fetch(16'hB400);
`ifdef CTRL_STACK_EN
    chk("pop2_arf", ARF_RegSel, 8'h03);
    chk("pop2_fs", ARF_FunSel, 8'h01);
    tick;
    chk("pop3_dsel", ARF_OutDSel, 8'h03);
    chk("pop3_cs", Mem_CS, 8'h00);
    chk("pop3_mxa", MuxASel, 8'h01);
    chk("pop3_rf", RF_RegSel, 8'h0D);
`else
    idle_chk("pop");
`endif
    tick;
    fetch(16'hF000);
    idle_chk("hlt2");
    chk("hlt2_halt", Halt, 8'h00);
    tick;
    for (int i = 0; i < 20; i++) begin
      chk("halt", Halt, 8'h01);
      idle_chk("halt");
      tick;
    end
    Reset = 1'b1;
    tick;
    chk("hrst_halt", Halt, 8'h00);
    chk("hrst_rffs", RF_FunSel, 8'h03);
    chk("hrst_arf", ARF_RegSel, 8'h00);
    Reset = 1'b0;
    tick;
    fetch(16'h0880);
    Reset = 1'b1;
    tick;
    chk("mrst_arffs", ARF_FunSel, 8'h03);
    chk("mrst_rf", RF_RegSel, 8'h00);
    Reset = 1'b0;
    tick;
    chk("mrst_t0", IR_Enable, 8'h01);
    chk("mrst_lh", IR_LH, 8'h00);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
